// File: rtl/fetch.sv
// Instruction-fetch stage: one outstanding imem read, 2-entry {pc+4, instr} buffer toward decode,
// and single-delay-slot redirect handling.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_we,
  input  logic [31:0] pc_data,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] ir
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        out_q, out_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        kill_q, kill_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] slot0_q, slot0_d;
  logic [63:0] slot1_q, slot1_d;

  logic        pop, ack, push, issue, redir;
  logic [2:0]  occ;
  logic [63:0] new_entry;

  always_comb begin
    pop       = (count_q != 2'd0) && !stall;
    ack       = imem_ack && out_q;
    push      = ack && !kill_q;
    occ       = {1'b0, count_q} + {2'b00, out_q} - {2'b00, pop};
    issue     = rst_n && (!out_q || imem_ack) && (occ < 3'd2);
    redir     = pc_we && pop;
    new_entry = {out_addr_q + 32'd4, imem_rdata};
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign valid     = (count_q != 2'd0);
  assign pc        = valid ? slot0_q[63:32] : 32'h0;
  assign ir        = valid ? slot0_q[31:0]  : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    out_addr_d = out_addr_q;
    kill_d     = kill_q;
    count_d    = count_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;

    if (issue) begin
      out_d      = 1'b1;
      out_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else if (ack) begin
      out_d = 1'b0;
    end
    if (redir) begin
      fetch_pc_d = pc_data;
    end

    if (ack && kill_q) begin
      kill_d = 1'b0;
    end
    // The delay slot is already buffered or in flight, so anything issued now is beyond it.
    if (redir && issue && (count_q == 2'd2 || out_q)) begin
      kill_d = 1'b1;
    end

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = new_entry;
        else                 slot1_d = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = new_entry;
        end else begin
          slot0_d = new_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= 1'b0;
      out_addr_q <= 32'h0;
      kill_q     <= 1'b0;
      count_q    <= 2'd0;
      slot0_q    <= 64'h0;
      slot1_q    <= 64'h0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      out_addr_q <= out_addr_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

endmodule
